serial_left_shifter: RTL

//  Multi-cycle left shifter/rotator for the XMakina multi-cycle datapath; the

---
 rtl/serial_left_shifter_if.sv | 27 ++
 rtl/serial_left_shifter.sv | 112 +++++++++++
 2 files changed

// File: rtl/serial_left_shifter_if.sv
// Request/response bundle for the serial left shifter.
// The execute FSM drives the master side; the shifter is the slave.
interface serial_left_shifter_if #(
  parameter int WORD = 16
);
  localparam int SW = $clog2(WORD);

  logic            start;
  logic [1:0]      operation;
  logic [SW-1:0]   shift;
  logic [WORD-1:0] in;
  logic [3:0]      status_old;
  logic            busy;
  logic            done;
  logic [WORD-1:0] out;
  logic [3:0]      status_new;

  modport master (
    output start, operation, shift, in, status_old,
    input  busy, done, out, status_new
  );

  modport slave (
    input  start, operation, shift, in, status_old,
    output busy, done, out, status_new
  );
endinterface

// File: rtl/serial_left_shifter.sv
// Multi-cycle left shifter / rotate-through-carry.
// One bit moves per clock; a start/done handshake brackets each operation.
// Status layout: [0]=C [1]=Z [2]=N [3]=V.
module serial_left_shifter #(
  parameter int WORD = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_left_shifter_if.slave  bus
);
  localparam int SW = $clog2(WORD);

  localparam logic [1:0] OP_SLL = 2'd0;
  localparam logic [1:0] OP_ROL = 2'd1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic [WORD-1:0] r_data;
  logic            r_c;
  logic [SW-1:0]   r_cnt;
  logic [1:0]      r_op;
  logic [3:0]      r_stat_old;
  logic [WORD-1:0] r_out;
  logic [3:0]      r_status;

  logic            w_pass;
  logic            w_finish;
  logic            w_fill;
  logic [3:0]      w_status;

  // Both encodings 2 and 3 pass the operand through untouched.
  assign w_pass   = r_op[1];
  assign w_finish = (r_cnt == '0) || w_pass;
  // Rotate feeds the carry back into bit 0, making a WORD+1 bit ring.
  assign w_fill   = (r_op == OP_ROL) ? r_c : 1'b0;

  // Flags computed from the working register at the moment it is committed.
  assign w_status = w_pass ? r_stat_old
                           : {r_stat_old[3], r_data[WORD-1], ~|r_data, r_c};

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state: start is only looked at in IDLE, DONE always lasts one cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_SHIFT;
      S_SHIFT: if (w_finish)  w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand capture in IDLE, then one shift step per clock in SHIFT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data     <= '0;
      r_c        <= 1'b0;
      r_cnt      <= '0;
      r_op       <= OP_SLL;
      r_stat_old <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_data     <= bus.in;
            r_c        <= bus.status_old[0];
            r_cnt      <= bus.shift;
            r_op       <= bus.operation;
            r_stat_old <= bus.status_old;
          end
        end
        S_SHIFT: begin
          if (!w_finish) begin
            r_c   <= r_data[WORD-1];
            r_data <= {r_data[WORD-2:0], w_fill};
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Result and flags commit only on the edge that enters DONE, then hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out    <= '0;
      r_status <= '0;
    end else if (r_state == S_SHIFT && w_finish) begin
      r_out    <= r_data;
      r_status <= w_status;
    end
  end

  assign bus.busy       = (r_state == S_SHIFT);
  assign bus.done       = (r_state == S_DONE);
  assign bus.out        = r_out;
  assign bus.status_new = r_status;

endmodule
